irq_pulse_gen: RTL and testbench
================================

# irq_pulse_gen

Transmit side of the core's interrupt-request bus. Collects device interrupt lines and a built-in interval timer, and drives the 16-bit `interrupts` vector. The control register file ORs that vector into its pending register, but only on non-stall cycles. This block therefore holds every request until a non-stall clock edge has consumed it, so no request is lost under pipeline stalls.

## Interface
- `NUM_IRQ`, 16: implemented lines, 1..16; bits at and above `NUM_IRQ` read 0.
- `TIMER_W`, 32: timer counter/reload width, 8..32.
- `clk` in 1: core clock.
- `rst` in 1: reset, asynchronous, active-high; one clock.
- `irq_req` in 16: device request lines; bit 0 is ORed with the timer tick.
- `edge_mode` in 16: per line, 1 = rising-edge triggered, 0 = level triggered; quasi-static.
- `stall` in 1: same `stall` that gates the control register file.
- `timer_wen` in 1: load timer.
- `timer_wdata` in TIMER_W: reload value; 0 disables the timer.
- `interrupts` out 16: request vector to the control register file; registered.
- `timer_count` out TIMER_W: current down-counter value.
- `timer_tick` out 1: one-cycle strobe on timer expiry.

## Operation
- `s` = line value after the optional synchronizer. `s_d` = `s` delayed one cycle.
- Per-line event `ev[i]`:
  - edge mode: `s[i] & ~s_d[i]`;
  - level mode: `s[i]`.
- `ev[0]` is additionally ORed with `timer_tick`.
- Pending register `pend`; `interrupts = pend`. On each posedge:
  - `stall=0`: the consumer samples `pend`; `pend <= ev`.
  - `stall=1`: nothing is consumed; `pend <= pend | ev`.
- Multiple events on one line while it is pending merge into one request. This is allowed because the consumer ORs.
- A level line held high re-presents its request on every non-stall cycle.
- Timer: registers `reload` and `count`. Running when `reload != 0`. Each cycle while running:
  - `count==1`: `timer_tick=1` that cycle (combinational from `count`); `count <= reload`.
  - otherwise: `count <= count-1`.
- Timer is free-running. `stall` does not pause it; a tick that occurs during a stall is held in `pend[0]`.
- `timer_wen`: `reload <= timer_wdata` and `count <= timer_wdata`.
  - A write in the same cycle as a tick: the write wins for `count`/`reload`, but the tick in that cycle still raises `ev[0]`.
  - Writing 0 stops the timer with `count=0`, and no further ticks occur.
  - Writing 1 gives a tick every cycle.
- Reset values: `pend`, `interrupts`, `s`, `s_d`, synchronizer flops, `count`, `reload`, `timer_tick` are all 0.
- An edge-mode line already high when reset releases produces exactly one event, because `s_d` resets to 0.
- Reset asserted mid-operation discards all pending requests and stops the timer.

## Timing
- Without sync, `irq_req` high before posedge k:
  - `pend` set at k;
  - `interrupts` high after k;
  - consumed at the first posedge ≥ k+1 with `stall=0`.
- With sync: the same sequence, 2 cycles later.
- Timer write at posedge k with value N (N>1), no later writes:
  - `timer_tick` asserts during the cycle after posedge k+N-1;
  - `interrupts[0]` is high after posedge k+N;
  - period N cycles.
- A `pend` bit stays high through any number of stall cycles and clears at the first non-stall edge, unless a new event arrives in that same cycle.
- No combinational path from `irq_req` or `stall` to `interrupts`.

## Configuration
- `IRQ_SYNC_EN`:
  - defined: each `irq_req` bit passes a 2-flop synchronizer before edge detection (+2 cycles latency); lines may be asynchronous.
  - undefined: `irq_req` is used directly and must be synchronous to `clk`.
- The timer path (internal, synchronous) is never synchronized.

## Test plan
- Edge line 5, `edge_mode[5]=1`, `irq_req[5]` held high 10 cycles, `stall=0` → `interrupts[5]` high for exactly 1 cycle; no second pulse until the line falls and rises again.
- Edge line 3 pulses while `stall=1` for 6 cycles → `interrupts[3]` stays high all 6 cycles plus through the first non-stall edge, then 0; a second pulse during the same stall window still yields a single merged request.
- Level line 7 high with stall toggling every cycle → `interrupts[7]` continuously 1; line drops → clears after the next non-stall edge.
- `timer_wdata=4` written once, `stall=0` → `timer_tick` every 4 cycles; `interrupts[0]` pulses 1 cycle after each tick; `timer_count` sequence 4,3,2,1,4…
- Timer write of 0 on the tick cycle → that tick is delivered, then no further ticks, `timer_count=0`; `rst` asserted mid-run with `pend=16'h00A1` → `interrupts=0` immediately (async), timer stopped.
- With `IRQ_SYNC_EN` defined, line 2 rising before posedge k → `pend[2]` set at posedge k+2, not earlier.

Source files
------------

// File: rtl/irq_pulse_gen_if.sv
// irq_pulse_gen_if: request/timer bus between the interrupt sources and
// irq_pulse_gen. The master drives device lines, stall and timer writes;
// the slave (irq_pulse_gen) returns the interrupt vector and timer state.
interface irq_pulse_gen_if #(
  parameter int TIMER_W = 32
) ();
  logic [15:0]        irq_req;
  logic [15:0]        edge_mode;
  logic               stall;
  logic               timer_wen;
  logic [TIMER_W-1:0] timer_wdata;
  logic [15:0]        interrupts;
  logic [TIMER_W-1:0] timer_count;
  logic               timer_tick;

  modport master (
    output irq_req, edge_mode, stall, timer_wen, timer_wdata,
    input  interrupts, timer_count, timer_tick
  );

  modport slave (
    input  irq_req, edge_mode, stall, timer_wen, timer_wdata,
    output interrupts, timer_count, timer_tick
  );
endinterface

// File: rtl/irq_pulse_gen.sv
// irq_pulse_gen: collects device interrupt lines plus an interval timer and
// presents a registered request vector that holds each request until a
// non-stall edge has consumed it.
// Optional: define IRQ_SYNC_EN to pass every irq_req bit through a 2-flop
// synchronizer before edge detection (+2 cycles latency).

// One interrupt line: optional sync, edge/level event, stall-held pending bit.
module irq_pulse_line (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic edge_mode,
  input  logic stall,
  input  logic extra_ev,
  output logic pend
);
  logic s, s_d, ev;

`ifdef IRQ_SYNC_EN
  logic [1:0] sync;

  // Two-flop synchronizer for lines that may be asynchronous to clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b00;
    else     sync <= {sync[0], req};
  end

  assign s = sync[1];
`else
  assign s = req;
`endif

  // Previous line value; resets low so a line already high yields one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) s_d <= 1'b0;
    else     s_d <= s;
  end

  assign ev = (edge_mode ? (s & ~s_d) : s) | extra_ev;

  // Consumer takes pend on non-stall edges; under stall, accumulate events.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        pend <= 1'b0;
    else if (stall) pend <= pend | ev;
    else            pend <= ev;
  end
endmodule

module irq_pulse_gen #(
  parameter int NUM_IRQ = 16,
  parameter int TIMER_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  irq_pulse_gen_if.slave  bus
);
  logic [TIMER_W-1:0] reload, count;
  logic               tick;
  logic [15:0]        pend;
  logic [15:0]        extra_ev;

  // Expiry strobe is combinational from count so it lines up with the reload.
  assign tick = (reload != '0) && (count == TIMER_W'(1));

  // Free-running down-counter; a write overrides the reload in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reload <= '0;
      count  <= '0;
    end else if (bus.timer_wen) begin
      reload <= bus.timer_wdata;
      count  <= bus.timer_wdata;
    end else if (reload != '0) begin
      count  <= tick ? reload : count - TIMER_W'(1);
    end
  end

  // Timer tick shares line 0 with the device request.
  assign extra_ev = {15'b0, tick};

  for (genvar i = 0; i < 16; i++) begin : g_line
    if (i < NUM_IRQ) begin : g_on
      irq_pulse_line u_line (
        .clk       (clk),
        .rst       (rst),
        .req       (bus.irq_req[i]),
        .edge_mode (bus.edge_mode[i]),
        .stall     (bus.stall),
        .extra_ev  (extra_ev[i]),
        .pend      (pend[i])
      );
    end else begin : g_off
      assign pend[i] = 1'b0;
    end
  end

  assign bus.interrupts  = pend;
  assign bus.timer_count = count;
  assign bus.timer_tick  = tick;
endmodule

// File: tb/tb_irq_pulse_gen.sv
// tb_irq_pulse_gen: directed stimulus against a behavioural model of the
// request vector and interval timer, plus hand-computed literal checks.
module tb_irq_pulse_gen;
  localparam int TW = 32;
`ifdef IRQ_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  irq_pulse_gen_if #(.TIMER_W(TW)) bus ();

  irq_pulse_gen #(.NUM_IRQ(16), .TIMER_W(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model: pending vector from sampled line history; timer from the time of
  // the last write and its period (tick when elapsed edges are a multiple).
  logic [15:0] m_pend = '0, m_sprev = '0, m_h1 = '0, m_h2 = '0;
  int m_c = 0, m_wk = 0, m_n = 0;

  always @(posedge clk or posedge rst) begin : model
    logic [15:0] s, ev;
    logic        tk;
    if (rst) begin
      m_pend <= '0; m_sprev <= '0; m_h1 <= '0; m_h2 <= '0;
      m_c <= 0; m_wk <= 0; m_n <= 0;
    end else begin
      s  = (LAT == 0) ? bus.irq_req : m_h2;
      tk = (m_n != 0) && (m_c > m_wk) && ((m_c - m_wk) % m_n == 0);
      ev = (bus.edge_mode & s & ~m_sprev) | (~bus.edge_mode & s);
      ev[0] = ev[0] | tk;
      m_pend  <= bus.stall ? (m_pend | ev) : ev;
      m_h1    <= bus.irq_req;
      m_h2    <= m_h1;
      m_sprev <= s;
      if (bus.timer_wen) begin
        m_wk <= m_c;
        m_n  <= int'(bus.timer_wdata);
      end
      m_c <= m_c + 1;
    end
  end

  function automatic logic [63:0] exp_cnt();
    if (m_n == 0) return 64'd0;
    return 64'(m_n - ((m_c - 1 - m_wk) % m_n));
  endfunction

  function automatic logic [63:0] exp_tick();
    return 64'((m_n != 0) && ((m_c - m_wk) % m_n == 0));
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock; outputs compared against the model at the falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    chk("model_interrupts", 64'(bus.interrupts), 64'(m_pend));
    chk("model_count", 64'(bus.timer_count), exp_cnt());
    chk("model_tick", 64'(bus.timer_tick), exp_tick());
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int hi, rises;
    logic prev;
    bus.irq_req = '0; bus.edge_mode = 16'h002C; bus.stall = 1'b0;
    bus.timer_wen = 1'b0; bus.timer_wdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_interrupts", 64'(bus.interrupts), 64'h0);
    chk("reset_count", 64'(bus.timer_count), 64'h0);
    chk("reset_tick", 64'(bus.timer_tick), 64'h0);
    rst = 1'b0;
    cyc();

    // Edge line 5 held high 10 cycles: exactly one pulse, again after re-rise
    bus.irq_req[5] = 1'b1; hi = 0;
    repeat (10) begin cyc(); hi += int'(bus.interrupts[5]); end
    chk("edge5_single_pulse", 64'(hi), 64'd1);
    bus.irq_req[5] = 1'b0;
    repeat (3) cyc();
    bus.irq_req[5] = 1'b1; hi = 0;
    repeat (4) begin cyc(); hi += int'(bus.interrupts[5]); end
    chk("edge5_repulse", 64'(hi), 64'd1);
    bus.irq_req[5] = 1'b0;
    repeat (LAT + 2) cyc();

    // Edge line 3 under a 6-cycle stall, two pulses merge into one request
    bus.stall = 1'b1; bus.irq_req[3] = 1'b1; hi = 0; rises = 0; prev = 1'b0;
    for (int j = 0; j < 6; j++) begin
      cyc();
      hi += int'(bus.interrupts[3]);
      if (bus.interrupts[3] && !prev) rises++;
      prev = bus.interrupts[3];
      bus.irq_req[3] = (j == 2);
    end
    chk("edge3_held_in_stall", 64'(hi), 64'(6 - LAT));
    chk("edge3_merged", 64'(rises), 64'd1);
    bus.stall = 1'b0;
    cyc();
    chk("edge3_cleared", 64'(bus.interrupts[3]), 64'd0);

    // Level line 7 with stall toggling: continuously requested
    bus.irq_req[7] = 1'b1;
    for (int j = 0; j < 10; j++) begin
      bus.stall = j[0];
      cyc();
      if (j >= LAT) chk("level7_held", 64'(bus.interrupts[7]), 64'd1);
    end
    bus.irq_req[7] = 1'b0; bus.stall = 1'b0;
    repeat (LAT + 1) cyc();
    chk("level7_cleared", 64'(bus.interrupts[7]), 64'd0);

    // Timer period 4: count 4,3,2,1,4...; interrupts[0] one cycle after tick
    bus.timer_wen = 1'b1; bus.timer_wdata = 32'd4;
    cyc();
    bus.timer_wen = 1'b0;
    chk("timer_load", 64'(bus.timer_count), 64'd4);
    for (int j = 0; j < 8; j++) begin
      cyc();
      chk("timer_count_seq", 64'(bus.timer_count), 64'((j % 4 == 0) ? 3 : (j % 4 == 1) ? 2 : (j % 4 == 2) ? 1 : 4));
      chk("timer_tick_seq", 64'(bus.timer_tick), 64'(j % 4 == 2));
      chk("timer_irq0_seq", 64'(bus.interrupts[0]), 64'(j % 4 == 3));
    end

    // Write 0 during a tick: that tick is delivered, then the timer stops
    for (int i = 0; i < 10 && !bus.timer_tick; i++) cyc();
    chk("wait_tick", 64'(bus.timer_tick), 64'd1);
    bus.timer_wen = 1'b1; bus.timer_wdata = '0;
    cyc();
    bus.timer_wen = 1'b0;
    chk("stop_tick_delivered", 64'(bus.interrupts[0]), 64'd1);
    chk("stop_count_zero", 64'(bus.timer_count), 64'd0);
    hi = 0;
    repeat (6) begin cyc(); hi += int'(bus.timer_tick) + int'(bus.interrupts[0]); end
    chk("stop_no_more_ticks", 64'(hi), 64'd0);

    // Period 1: tick every cycle, then stop again
    bus.timer_wen = 1'b1; bus.timer_wdata = 32'd1;
    cyc();
    bus.timer_wen = 1'b0;
    repeat (3) cyc();
    chk("period1_irq0", 64'(bus.interrupts[0]), 64'd1);
    bus.timer_wen = 1'b1; bus.timer_wdata = 32'd0;
    cyc();
    bus.timer_wen = 1'b0;
    repeat (2) cyc();

    // Async reset mid-run with pend = 00A1 and the timer running
    bus.timer_wen = 1'b1; bus.timer_wdata = 32'd9;
    cyc();
    bus.timer_wen = 1'b0;
    bus.stall = 1'b1;
    bus.irq_req[0] = 1'b1; bus.irq_req[5] = 1'b1; bus.irq_req[7] = 1'b1;
    repeat (LAT + 1) cyc();
    chk("pend_before_reset", 64'(bus.interrupts), 64'h00A1);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_interrupts", 64'(bus.interrupts), 64'h0);
    chk("async_reset_count", 64'(bus.timer_count), 64'h0);
    cyc();
    rst = 1'b0; bus.stall = 1'b0;
    bus.irq_req[0] = 1'b0; bus.irq_req[7] = 1'b0;
    hi = 0;
    repeat (LAT + 4) begin cyc(); hi += int'(bus.interrupts[5]); end
    chk("edge_high_at_release", 64'(hi), 64'd1);
    chk("timer_stopped_after_reset", 64'(bus.timer_count), 64'd0);
    bus.irq_req[5] = 1'b0;
    repeat (LAT + 2) cyc();

    // Line 2 rising before edge k: set at k (no sync) or k+2 (sync)
    bus.irq_req[2] = 1'b1;
    cyc();
    chk("line2_at_k", 64'(bus.interrupts[2]), 64'(LAT == 0));
    cyc();
    chk("line2_at_k1", 64'(bus.interrupts[2]), 64'd0);
    cyc();
    chk("line2_at_k2", 64'(bus.interrupts[2]), 64'(LAT == 2));
    bus.irq_req[2] = 1'b0;

    // Mixed patterns against the model
    bus.timer_wen = 1'b1; bus.timer_wdata = 32'd3;
    cyc();
    bus.timer_wen = 1'b0;
    for (int j = 0; j < 12; j++) begin
      bus.irq_req = 16'(16'hA5C3 >> j) ^ 16'(j * 16'h1111);
      bus.stall = (j % 3 == 1);
      cyc();
    end
    bus.irq_req = '0; bus.stall = 1'b0;
    repeat (LAT + 2) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
